// File: rtl/dmux_1by8_sel_seq.sv
// Select/data sequencer for the 1-to-8 demux: sweeps s over the enabled
// channels in ascending order, holding each for DWELL cycles.
module dmux_1by8_sel_seq #(
  parameter int unsigned DWELL = 10,
  parameter int unsigned CW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       loop,
  input  logic [7:0] chan_en,
  input  logic       din,
  output logic [2:0] s,
  output logic       i,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    mask, mask_d;
  logic [2:0]    s_d;
  logic [2:0]    up_idx, low_idx, start_idx;
  logic          up_found;

  // Nearest enabled index above s, lowest enabled index, and first channel of a new sweep.
  always_comb begin
    up_found  = 1'b0;
    up_idx    = s;
    low_idx   = 3'd0;
    start_idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (mask[k]) low_idx = 3'(k);
      if (chan_en[k]) start_idx = 3'(k);
      if (mask[k] && (k > int'(s))) begin
        up_idx   = 3'(k);
        up_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    s_d     = s;
    cnt_d   = cnt;
    mask_d  = mask;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (chan_en != 8'd0) begin
            mask_d  = chan_en;
            s_d     = start_idx;
            cnt_d   = '0;
            state_d = DRIVE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt == LAST) begin
          cnt_d = '0;
          if (up_found)  s_d = up_idx;
          else if (loop) s_d = low_idx;
          else           state_d = DONE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s     <= 3'd0;
      cnt   <= '0;
      mask  <= 8'd0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      s     <= s_d;
      cnt   <= cnt_d;
      mask  <= mask_d;
      valid <= (state_d == DRIVE);
      busy  <= (state_d == DRIVE);
      done  <= (state_d == DONE);
    end
  end

  assign i = din & valid;

endmodule

// File: tb/tb_dmux_1by8_sel_seq.sv
// Directed bench for the demux select sequencer, using three dwell settings.
module tb_dmux_1by8_sel_seq;

  logic       clk = 1'b0;
  logic       rst_n, abort, loop, din;
  logic [7:0] chan_en;
  logic       start1, start2, start3;

  logic [2:0] s1, s2, s3;
  logic       i1, i2, i3, valid1, valid2, valid3;
  logic       busy1, busy2, busy3, done1, done2, done3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmux_1by8_sel_seq #(.DWELL(1), .CW(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .loop(loop),
    .chan_en(chan_en), .din(din), .s(s1), .i(i1), .valid(valid1),
    .busy(busy1), .done(done1));

  dmux_1by8_sel_seq #(.DWELL(2), .CW(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .loop(loop),
    .chan_en(chan_en), .din(din), .s(s2), .i(i2), .valid(valid2),
    .busy(busy2), .done(done2));

  dmux_1by8_sel_seq #(.DWELL(3), .CW(8)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort), .loop(loop),
    .chan_en(chan_en), .din(din), .s(s3), .i(i3), .valid(valid3),
    .busy(busy3), .done(done3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  initial begin
    logic [2:0] masked_seq [4];
    masked_seq[0] = 3'd0; masked_seq[1] = 3'd2;
    masked_seq[2] = 3'd5; masked_seq[3] = 3'd7;

    rst_n = 1'b0; abort = 1'b0; loop = 1'b0; din = 1'b1; chan_en = 8'd0;
    start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s",     32'(s2), 32'd0);
    check("rst_valid", 32'(valid2), 32'd0);
    check("rst_busy",  32'(busy2), 32'd0);
    check("rst_done",  32'(done2), 32'd0);
    check("rst_i",     32'(i2), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweep, DWELL=2
    chan_en = 8'hFF; loop = 1'b0; din = 1'b1; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      check($sformatf("full_s%0d", c), 32'(s2), 32'(c / 2));
      check($sformatf("full_valid%0d", c), 32'(valid2), 32'd1);
      check($sformatf("full_i%0d", c), 32'(i2), 32'd1);
      check($sformatf("full_busy%0d", c), 32'(busy2), 32'd1);
      check($sformatf("full_done%0d", c), 32'(done2), 32'd0);
      @(negedge clk);
    end
    check("full_end_done",  32'(done2), 32'd1);
    check("full_end_busy",  32'(busy2), 32'd0);
    check("full_end_valid", 32'(valid2), 32'd0);
    check("full_end_s",     32'(s2), 32'd7);
    @(negedge clk);
    check("full_post_done", 32'(done2), 32'd0);

    // Masked sweep, DWELL=3
    chan_en = 8'b1010_0101; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("mask_s%0d", c), 32'(s3), 32'(masked_seq[c / 3]));
      check($sformatf("mask_valid%0d", c), 32'(valid3), 32'd1);
      check($sformatf("mask_done%0d", c), 32'(done3), 32'd0);
      @(negedge clk);
    end
    check("mask_end_done",  32'(done3), 32'd1);
    check("mask_end_valid", 32'(valid3), 32'd0);
    @(negedge clk);

    // Looping, DWELL=1; loop dropped while on channel 1
    chan_en = 8'b0100_0010; loop = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      check($sformatf("loop_s%0d", c), 32'(s1), (c % 2 == 0) ? 32'd1 : 32'd6);
      check($sformatf("loop_valid%0d", c), 32'(valid1), 32'd1);
      check($sformatf("loop_done%0d", c), 32'(done1), 32'd0);
      if (c == 6) loop = 1'b0;
      @(negedge clk);
    end
    check("loop_last_s",     32'(s1), 32'd6);
    check("loop_last_valid", 32'(valid1), 32'd1);
    check("loop_last_done",  32'(done1), 32'd0);
    @(negedge clk);
    check("loop_end_done",  32'(done1), 32'd1);
    check("loop_end_valid", 32'(valid1), 32'd0);
    check("loop_end_s",     32'(s1), 32'd6);
    @(negedge clk);

    // Abort on channel 3 at dwell expiry; a start and mask change mid-sweep are ignored
    chan_en = 8'h18; start2 = 1'b1;
    @(negedge clk);
    check("abort_s0", 32'(s2), 32'd3);
    chan_en = 8'h01;
    @(negedge clk);
    check("abort_s1", 32'(s2), 32'd3);
    check("abort_busy1", 32'(busy2), 32'd1);
    start2 = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", 32'(valid2), 32'd0);
    check("abort_busy",  32'(busy2), 32'd0);
    check("abort_done",  32'(done2), 32'd0);
    check("abort_s",     32'(s2), 32'd3);
    @(negedge clk);
    check("abort_idle_busy", 32'(busy2), 32'd0);
    check("abort_idle_done", 32'(done2), 32'd0);

    // Zero mask
    chan_en = 8'd0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("zero_done",  32'(done2), 32'd1);
    check("zero_valid", 32'(valid2), 32'd0);
    check("zero_busy",  32'(busy2), 32'd0);
    check("zero_s",     32'(s2), 32'd3);
    @(negedge clk);
    check("zero_post_done", 32'(done2), 32'd0);

    // Data gating in IDLE
    din = 1'b1; #1;
    check("gate_i_hi", 32'(i2), 32'd0);
    din = 1'b0; #1;
    check("gate_i_lo", 32'(i2), 32'd0);
    din = 1'b1;
    @(negedge clk);

    // Asynchronous reset while s=4
    chan_en = 8'hFF; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (8) @(negedge clk);
    check("rstmid_s_before", 32'(s2), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_s",     32'(s2), 32'd0);
    check("rstmid_valid", 32'(valid2), 32'd0);
    check("rstmid_busy",  32'(busy2), 32'd0);
    check("rstmid_i",     32'(i2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_wait_busy",  32'(busy2), 32'd0);
    check("rstmid_wait_valid", 32'(valid2), 32'd0);
    check("rstmid_wait_s",     32'(s2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmux_1by8_sel_seq.md
Name: dmux_1by8_sel_seq

Overview:
Upstream sequencer for the 1-to-8 demultiplexer stage. It generates the 3-bit select `s` and the data bit `i` that feed the demux.
- On a start request it steps `s` through every enabled channel in ascending order.
- Each selected channel is held for a fixed dwell time while `din` is gated onto `i`.
- It replaces hand-written select sweeps with a repeatable, maskable, optionally looping schedule.

Parameters:
- DWELL, 10, cycles each select value is held; legal range 1..255.
- CW, 8, width of the dwell counter; must satisfy 2^CW > DWELL.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sweep; sampled only in IDLE.
- abort  input  1  synchronous stop request; wins over every other event.
- loop  input  1  1 = wrap to the lowest enabled channel after the highest one; 0 = single pass. Sampled live.
- chan_en  input  8  channel enable mask; bit k enables select value k. Captured at start.
- din  input  1  data bit to route to the selected channel.
- s  output  3  demux select, registered.
- i  output  1  demux data input; equals din AND valid, combinational.
- valid  output  1  high while a channel is being driven (DRIVE state).
- busy  output  1  high from the cycle after an accepted start until DONE or abort.
- done  output  1  one-cycle pulse at the end of a pass when loop=0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: s=0, valid=0, busy=0, done=0, so i=0. State=IDLE, dwell counter=0, mask register=0.
- Reset asserted mid-sweep: all outputs clear immediately, with no wait for a clock edge.
- States: IDLE, DRIVE, DONE.
- IDLE, start=1, abort=0, chan_en!=0:
  - Capture chan_en into the mask register.
  - Load s with the index of the lowest set bit and clear the counter.
  - Next state DRIVE. valid and busy go high on the following cycle (1-cycle latency from start).
- IDLE, start=1, chan_en==0: go to DONE. done pulses; busy and valid stay 0; s is unchanged.
- IDLE, start=1, abort=1: start is ignored; stay in IDLE.
- DRIVE:
  - valid=1 and busy=1; counter increments each cycle.
  - When the counter reaches DWELL-1, on the next edge:
    - If a higher enabled index exists in the mask: s takes the nearest such index, the counter clears, and the state stays DRIVE. There is no gap cycle; valid stays high.
    - Else, if loop=1: s takes the lowest enabled index, the counter clears, and the state stays DRIVE.
    - Else: go to DONE; s holds the last index.
- DONE: valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
- abort=1 in DRIVE: next edge goes to IDLE with valid=0 and busy=0. No done pulse; s holds. Abort beats a simultaneous dwell expiry.
- start and chan_en changes while busy are ignored; the captured mask governs the whole sweep.
- Single enabled channel with loop=1: s stays constant, valid stays high indefinitely, and the counter keeps wrapping.
- DWELL=1: s advances every cycle.
- Counter width: CW bits, compared against DWELL-1. No overflow is possible within the legal DWELL range.

Test Plan:
1. Full sweep. DWELL=2, chan_en=8'hFF, loop=0, din=1, start pulse.
   -> s = 0,0,1,1,...,7,7 over 16 cycles with valid=1 and i=1 throughout, then one done pulse; busy high for exactly 16 cycles.
2. Masked sweep. chan_en=8'b1010_0101, DWELL=3, loop=0.
   -> s visits 0,2,5,7, each held 3 cycles; done pulses 12 cycles after valid rises.
3. Looping. chan_en=8'b0100_0010, DWELL=1, loop=1 -> s alternates 1,6,1,6,... with no done pulse. Then drop loop to 0 -> pass completes after s=6 and done pulses.
4. Abort. Assert abort while DRIVE is on channel 3 at the dwell-expiry cycle.
   -> Next cycle valid=0, busy=0, done=0, s=3. A start issued during the sweep had no effect.
5. Edge cases and data gating:
   - Zero mask: start with chan_en=0 -> done pulses the next cycle; valid and busy stay 0.
   - Data gating: din toggling in IDLE -> i stays 0.
6. Reset mid-sweep. Drop rst_n asynchronously between clock edges while s=4.
   -> s=0, valid=0, busy=0, i=0 immediately. After release, the block waits for a new start.
